// File: rtl/mac_pkg.sv
// Shared types for the MAC array sequencer: lane geometry, packed operand/result vectors,
// and the sequencer FSM state encoding.
package mac_pkg;

  localparam int unsigned Lanes = 4;
  localparam int unsigned OpW   = 8;
  localparam int unsigned ResW  = 32;
  localparam int unsigned IdxW  = $clog2(Lanes);

  typedef logic [Lanes*OpW-1:0]  op_vec_t;
  typedef logic [Lanes*ResW-1:0] res_vec_t;
  typedef logic [ResW-1:0]       res_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDrain
  } seq_state_e;

  // Extract result lane idx (o0 lives in the least significant word).
  function automatic res_word_t res_lane(input res_vec_t v, input logic [IdxW-1:0] idx);
    return v[idx*ResW +: ResW];
  endfunction

endpackage

// File: rtl/mac_seq_drain.sv
// Four-entry result capture and serializer: loads all lanes at once and streams them out
// as valid/ready beats, flagging the final lane with last_o.
module mac_seq_drain
  import mac_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  res_vec_t  load_data_i,
  input  logic      en_i,
  input  logic      ready_i,
  output logic      valid_o,
  output res_word_t data_o,
  output logic      last_o,
  output logic      done_o
);

  res_word_t         cap_q [Lanes];
  logic [IdxW-1:0]   idx_q;
  logic              at_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Lanes; i++) cap_q[i] <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      for (int i = 0; i < Lanes; i++) cap_q[i] <= res_lane(load_data_i, IdxW'(i));
      idx_q <= '0;
    end else if (en_i && ready_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign at_last = (idx_q == IdxW'(Lanes - 1));

  // Outputs are gated so nothing stale leaks out between jobs.
  always_comb begin
    valid_o = en_i;
    data_o  = en_i ? cap_q[idx_q] : '0;
    last_o  = en_i && at_last;
    done_o  = en_i && ready_i && at_last;
  end

endmodule

// File: rtl/mac_seq.sv
// Host-side sequencer for the 4-lane int8 MAC array: accepts a job, pulses start, waits for
// done, then drains four result beats. Define MAC_SEQ_TIMEOUT_EN for the done-wait timeout.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_vec_t          in_a,
  input  op_vec_t          in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output res_word_t        res_data,
  output logic             res_last,
  output logic             acc_start,
  output op_vec_t          acc_a,
  output op_vec_t          acc_b,
  input  logic             acc_done,
  input  res_vec_t         acc_o,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             err
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("mac_seq: TIMEOUT_CYC must be at least 1");
  end

  seq_state_e       state_q, state_d;
  op_vec_t          acc_a_q, acc_b_q;
  logic [CNT_W-1:0] jobs_q;
  logic             cap_load;
  res_vec_t         cap_data;
  logic             drain_done;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
  logic [WaitW-1:0] wait_cnt_q;
  logic             timeout;
  logic             err_q;
`endif

  always_comb begin
    state_d  = state_q;
    cap_load = 1'b0;
    cap_data = acc_o;
`ifdef MAC_SEQ_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (acc_done) begin
          cap_load = 1'b1;
          state_d  = StDrain;
`ifdef MAC_SEQ_TIMEOUT_EN
        end else if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1)) begin
          // Emit four zero beats so the host still sees a complete job.
          cap_load = 1'b1;
          cap_data = '0;
          timeout  = 1'b1;
          state_d  = StDrain;
`endif
        end
      end
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_a_q <= '0;
      acc_b_q <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        acc_a_q <= in_a;
        acc_b_q <= in_b;
      end
      if (drain_done) jobs_q <= jobs_q + 1'b1;
    end
  end

`ifdef MAC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StStart)     wait_cnt_q <= '0;
      else if (state_q == StWait) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  mac_seq_drain u_drain (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (cap_load),
    .load_data_i (cap_data),
    .en_i        (state_q == StDrain),
    .ready_i     (res_ready),
    .valid_o     (res_valid),
    .data_o      (res_data),
    .last_o      (res_last),
    .done_o      (drain_done)
  );

  // in_ready is held low while rst is asserted, even though state is already idle.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign acc_start = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign acc_a     = acc_a_q;
  assign acc_b     = acc_b_q;
  assign jobs_done = jobs_q;

endmodule
